// File: rtl/stoch_pkg.sv
// rtl/stoch_pkg.sv - shared state type and LFSR tap table for the stochastic generator
package stoch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Maximal-length Fibonacci taps, bit k-1 set for tap k; entry i serves width i+4
  localparam logic [15:0] TAP_TABLE [0:12] = '{
    16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
    16'h0500, 16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008
  };

  function automatic logic [15:0] tap_mask(input int n);
    if (n < 4 || n > 16) return 16'h0000;
    return TAP_TABLE[n - 4];
  endfunction

endpackage

// File: rtl/stoch_lfsr.sv
// rtl/stoch_lfsr.sv - N-bit maximal-length Fibonacci LFSR with load and step enable
module stoch_lfsr #(
  parameter int           N    = 8,
  parameter logic [N-1:0] INIT = {{(N-1){1'b0}}, 1'b1}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         en,
  output logic [N-1:0] q
);
  import stoch_pkg::*;

  localparam logic [15:0]  TAPS_FULL = tap_mask(N);
  localparam logic [N-1:0] TAPS      = TAPS_FULL[N-1:0];

  logic fb;

  assign fb = ^(q & TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= INIT;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= {q[N-2:0], fb};
    end
  end

endmodule

// File: rtl/stoch_gen.sv
// rtl/stoch_gen.sv - binary-to-stochastic bitstream generator, one 2^N-1 bit frame per start
// STOCH_GEN_BIPOLAR_EN selects two's complement (bipolar) encoding instead of unsigned.
module stoch_gen #(
  parameter int N    = 8,
  parameter int SEED = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] value,
  output logic         busy,
  output logic         valid,
  output logic         Y,
  output logic         done
);
  import stoch_pkg::*;

  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] SEED_RAW = SEED[N-1:0];
  localparam logic [N-1:0] SEED_EFF = (SEED_RAW == '0) ? ONE : SEED_RAW;
  localparam logic [N-1:0] LAST_IDX = {{(N-1){1'b1}}, 1'b0};

  state_t       state, state_nxt;
  logic [N-1:0] cnt, op_q, op_in, lfsr_q;
  logic         y_q, y_nxt, accept, last, lfsr_load, lfsr_en;

`ifdef STOCH_GEN_BIPOLAR_EN
  assign op_in = {~value[N-1], value[N-2:0]};
`else
  assign op_in = value;
`endif

  stoch_lfsr #(.N(N), .INIT(SEED_EFF)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED_EFF),
    .en   (lfsr_en),
    .q    (lfsr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The LFSR is reloaded every idle cycle, so it holds the seed when start
  // arrives and the accept edge can already register the first frame bit.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    y_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
          lfsr_en   = 1'b1;
          y_nxt     = (lfsr_q <= op_in);
        end else begin
          lfsr_load = 1'b1;
        end
      end
      RUN: begin
        last = (cnt == LAST_IDX);
        if (last) begin
          state_nxt = IDLE;
          lfsr_load = 1'b1;
        end else begin
          lfsr_en = 1'b1;
          y_nxt   = (lfsr_q <= op_q);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      op_q <= '0;
      y_q  <= 1'b0;
    end else begin
      y_q <= y_nxt;
      if (accept) begin
        cnt  <= '0;
        op_q <= op_in;
      end else if (state == RUN) begin
        cnt <= cnt + ONE;
      end
    end
  end

  assign busy  = (state == RUN);
  assign valid = busy;
  assign done  = last;
  assign Y     = y_q;

endmodule

// File: tb/tb_stoch_gen.sv
// tb/tb_stoch_gen.sv - self-checking bench for stoch_gen (N=8)
module tb_stoch_gen;
  localparam int N = 8;
  localparam int L = 255;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] value = '0;
  logic         busy, valid, Y, done;

  stoch_gen #(.N(N), .SEED(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value),
    .busy  (busy),
    .valid (valid),
    .Y     (Y),
    .done  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] v;
    int         exp_ones;
  } vec_t;

  vec_t         vecs [6];
  int           len, ones, nd, dat, len2, ones2, nd2, dat2, gap, busy_low;
  logic [L-1:0] bits, bits2, gold;
  logic [7:0]   va, vb, tmp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_ones(input logic [7:0] v);
`ifdef STOCH_GEN_BIPOLAR_EN
    return int'($signed(v)) + 128;
`else
    return int'(v);
`endif
  endfunction

  // Collects one frame starting at the current negedge while valid is high.
  task automatic collect(output int f_len, output int f_ones, output int f_nd,
                         output int f_dat, output logic [L-1:0] f_bits);
    f_len = 0; f_ones = 0; f_nd = 0; f_dat = -1; f_bits = '0;
    for (int c = 0; c < 300; c++) begin
      if (!valid) break;
      if (f_len < L) f_bits[f_len] = Y;
      f_ones += int'(Y);
      if (done) begin
        f_nd++;
        f_dat = f_len;
      end
      f_len++;
      @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [7:0] v, output int f_len, output int f_ones,
                           output int f_nd, output int f_dat, output logic [L-1:0] f_bits);
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(f_len, f_ones, f_nd, f_dat, f_bits);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef STOCH_GEN_BIPOLAR_EN
    vecs[0] = '{8'h00, 128};
    vecs[1] = '{8'h80, 0};
    vecs[2] = '{8'h7F, 255};
    vecs[3] = '{8'h01, 129};
    vecs[4] = '{8'hFF, 127};
    vecs[5] = '{8'hC0, 64};
`else
    vecs[0] = '{8'd0, 0};
    vecs[1] = '{8'd255, 255};
    vecs[2] = '{8'd128, 128};
    vecs[3] = '{8'd1, 1};
    vecs[4] = '{8'd77, 77};
    vecs[5] = '{8'd254, 254};
`endif

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_done", done, 0);
    check("rst_y", Y, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_valid", valid, 0);
    check("idle_y", Y, 0);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].v, len, ones, nd, dat, bits);
      check($sformatf("tbl%0d_len", i), len, L);
      check($sformatf("tbl%0d_ones", i), ones, vecs[i].exp_ones);
      check($sformatf("tbl%0d_ndone", i), nd, 1);
      check($sformatf("tbl%0d_done_pos", i), dat, L - 1);
    end

    // randomized values against the model
    for (int i = 0; i < 5; i++) begin
      va = 8'($urandom_range(0, 255));
      run_frame(va, len, ones, nd, dat, bits);
      check($sformatf("rnd%0d_len v=%0d", i, va), len, L);
      check($sformatf("rnd%0d_ones v=%0d", i, va), ones, model_ones(va));
      check($sformatf("rnd%0d_done_pos v=%0d", i, va), dat, L - 1);
    end

    // a larger magnitude sets a superset of bit positions
    for (int i = 0; i < 3; i++) begin
      va = 8'($urandom_range(0, 255));
      vb = 8'($urandom_range(0, 255));
      if (model_ones(va) > model_ones(vb)) begin
        tmp = va; va = vb; vb = tmp;
      end
      run_frame(va, len, ones, nd, dat, bits);
      run_frame(vb, len2, ones2, nd2, dat2, bits2);
      check($sformatf("subset%0d %0d<=%0d", i, va, vb), (bits & ~bits2) == '0 ? 1 : 0, 1);
    end

    // start and value change mid-frame are ignored
    @(negedge clk);
    value = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len = 0; ones = 0; nd = 0; busy_low = 0;
    for (int c = 0; c < 300; c++) begin
      if (!valid) break;
      ones += int'(Y);
      nd   += int'(done);
      if (!busy) busy_low++;
      len++;
      start = (len == 10);
      if (len == 10) value = 8'd3;
      @(negedge clk);
    end
    start = 1'b0;
    check("restart_len", len, L);
    check("restart_ones", ones, model_ones(8'd100));
    check("restart_ndone", nd, 1);
    check("restart_busy_low", busy_low, 0);
    check("restart_end_busy", busy, 0);
    @(negedge clk);
    check("restart_not_queued", valid, 0);

    // reset mid-frame, then the restarted frame matches a fresh one
    run_frame(8'd77, len, ones, nd, dat, gold);
    @(negedge clk);
    value = 8'd77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100; c++) @(negedge clk);
    check("abort_valid_before", valid, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_done", done, 0);
    check("abort_y", Y, 0);
    @(negedge clk);
    check("abort_done_held", done, 0);
    rst = 1'b0;
    run_frame(8'd77, len, ones, nd, dat, bits);
    check("abort_refr_len", len, L);
    check("abort_refr_ones", ones, model_ones(8'd77));
    check("abort_refr_same", (bits === gold) ? 1 : 0, 1);

    // start held high: back-to-back frames with one idle cycle
    @(negedge clk);
    value = 8'd200;
    start = 1'b1;
    @(negedge clk);
    collect(len, ones, nd, dat, bits);
    gap = 0;
    while (!valid && gap < 5) begin
      gap++;
      @(negedge clk);
    end
    collect(len2, ones2, nd2, dat2, bits2);
    start = 1'b0;
    check("b2b_len1", len, L);
    check("b2b_gap", gap, 1);
    check("b2b_len2", len2, L);
    check("b2b_ones", ones, model_ones(8'd200));
    check("b2b_same", (bits === bits2) ? 1 : 0, 1);
    for (int c = 0; c < 300 && busy; c++) @(negedge clk);
    check("b2b_drained", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
